// File: rtl/mmio_io_hub.sv
// Memory-mapped IO hub: switch bank, LED register, scanned seven-segment display, debounced button.
// Optional interrupt enable register and irq output are built only when IO_HUB_IRQ_EN is defined.
module mmio_io_hub #(
   parameter int          SW_W         = 16,
   parameter int          LED_W        = 16,
   parameter int          DIGITS       = 8,
   parameter int          DEBOUNCE_CYC = 200000,
   parameter int          SCAN_CYC     = 25000,
   parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FC00
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       addr,
   input  logic              wen,
   input  logic              ren,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   input  logic [SW_W-1:0]   sw_in,
   input  logic              btn_in,
   output logic [LED_W-1:0]  led_out,
   output logic [DIGITS-1:0] seg_an,
   output logic [7:0]        seg_cat,
   output logic              irq
);

   localparam int          DB_W     = $clog2(DEBOUNCE_CYC);
   localparam int          DIV_W    = $clog2(SCAN_CYC);
   localparam logic [31:0] LED_MASK = (LED_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << LED_W) - 32'd1);
   localparam logic [31:0] VAL_MASK = (DIGITS >= 8) ? 32'hFFFF_FFFF : ((32'd1 << (4 * DIGITS)) - 32'd1);
   localparam logic [31:0] DIG_MASK = (32'd1 << DIGITS) - 32'd1;
   localparam logic [31:0] CTL_MASK = DIG_MASK | (DIG_MASK << 8);

   logic             hit;
   logic [7:0]       off;
   logic             we_stat, we_led, we_val, we_ctl;
   logic [31:0]      sw_ext, sw_m, sw_s;
   logic             btn_m, btn_s, btn_db;
   logic [DB_W-1:0]  db_cnt;
   logic             db_done, db_rise, evt_clr;
   logic             evt;
   logic [7:0]       evt_cnt;
   logic [31:0]      led_q, segval_q, segctl_q;
   logic [DIV_W-1:0] div_q;
   logic             scan_tc, scan_run;
   logic [2:0]       idx_q, idx_n;
   logic [7:0]       blank_v, dp_v;
   logic [3:0]       nib;
   logic [DIGITS-1:0] an_n;
   logic [7:0]       cat_n;
   logic             irqen_rd;
   logic             unused_addr;

   assign unused_addr = ^addr[1:0];

   assign hit     = (addr[31:8] == BASE_ADDR[31:8]);
   assign off     = {addr[7:2], 2'b00};
   assign we_stat = wen && hit && (off == 8'h04);
   assign we_led  = wen && hit && (off == 8'h10);
   assign we_val  = wen && hit && (off == 8'h20);
   assign we_ctl  = wen && hit && (off == 8'h24);

   always_comb begin
      sw_ext = '0;
      sw_ext[SW_W-1:0] = sw_in;
   end

   assign db_done = (btn_s != btn_db) && (db_cnt == DB_W'(DEBOUNCE_CYC - 1));
   assign db_rise = db_done && btn_s;
   assign evt_clr = we_stat && wdata[0];

   assign scan_tc = (div_q == DIV_W'(SCAN_CYC - 1));

   // The first terminal count after reset lights digit 0; later ones advance the index.
   always_comb begin
      idx_n = idx_q;
      if (scan_tc) begin
         if (!scan_run || idx_q == 3'(DIGITS - 1))
            idx_n = 3'd0;
         else
            idx_n = idx_q + 3'd1;
      end
   end

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   assign blank_v = segctl_q[7:0];
   assign dp_v    = segctl_q[15:8];

   always_comb begin
      nib   = segval_q[{idx_n, 2'b00} +: 4];
      an_n  = '1;
      cat_n = 8'hFF;
      if (!blank_v[idx_n]) begin
         for (int k = 0; k < DIGITS; k++)
            an_n[k] = (idx_n != 3'(k));
         cat_n = {~dp_v[idx_n], hex7(nib)};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_m     <= '0;
         sw_s     <= '0;
         btn_m    <= 1'b0;
         btn_s    <= 1'b0;
         btn_db   <= 1'b0;
         db_cnt   <= '0;
         evt      <= 1'b0;
         evt_cnt  <= 8'd0;
         led_q    <= '0;
         segval_q <= '0;
         segctl_q <= '0;
         div_q    <= '0;
         idx_q    <= 3'd0;
         scan_run <= 1'b0;
         seg_an   <= '1;
         seg_cat  <= 8'hFF;
      end else begin
         sw_m  <= sw_ext;
         sw_s  <= sw_m;
         btn_m <= btn_in;
         btn_s <= btn_m;

         if (btn_s == btn_db)
            db_cnt <= '0;
         else if (db_done) begin
            db_cnt <= '0;
            btn_db <= btn_s;
         end else
            db_cnt <= db_cnt + 1'b1;

         // A new event outranks a simultaneous software clear.
         if (db_rise) begin
            evt     <= 1'b1;
            evt_cnt <= evt_cnt + 8'd1;
         end else if (evt_clr)
            evt <= 1'b0;

         if (we_led) led_q    <= wdata & LED_MASK;
         if (we_val) segval_q <= wdata & VAL_MASK;
         if (we_ctl) segctl_q <= wdata & CTL_MASK;

         if (scan_tc) begin
            div_q    <= '0;
            idx_q    <= idx_n;
            scan_run <= 1'b1;
            seg_an   <= an_n;
            seg_cat  <= cat_n;
         end else
            div_q <= div_q + 1'b1;
      end
   end

   assign led_out = led_q[LED_W-1:0];

`ifdef IO_HUB_IRQ_EN
   logic we_irqen, irqen_q, irq_q;

   assign we_irqen = wen && hit && (off == 8'h08);

   always_ff @(posedge clk) begin
      if (rst) begin
         irqen_q <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         if (we_irqen) irqen_q <= wdata[0];
         irq_q <= evt & irqen_q;
      end
   end

   assign irqen_rd = irqen_q;
   assign irq      = irq_q;
`else
   assign irqen_rd = 1'b0;
   assign irq      = 1'b0;
`endif

   always_comb begin
      rdata = '0;
      if (ren && hit) begin
         case (off)
            8'h00:   rdata = sw_s;
            8'h04:   rdata = {22'b0, evt_cnt, btn_db, evt};
            8'h08:   rdata = {31'b0, irqen_rd};
            8'h10:   rdata = led_q;
            8'h20:   rdata = segval_q;
            8'h24:   rdata = segctl_q;
            default: rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_io_hub.sv
// Directed bench for mmio_io_hub with DIGITS=4, DEBOUNCE_CYC=4, SCAN_CYC=3.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mmio_io_hub;
   localparam logic [31:0] BASE = 32'hFFFF_FC00;

   logic        clk = 1'b0;
   logic        rst, wen, ren, btn_in;
   logic [31:0] addr, wdata, rdata;
   logic [15:0] sw_in, led_out;
   logic [3:0]  seg_an;
   logic [7:0]  seg_cat;
   logic        irq;

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mmio_io_hub #(
      .SW_W(16), .LED_W(16), .DIGITS(4), .DEBOUNCE_CYC(4), .SCAN_CYC(3), .BASE_ADDR(BASE)
   ) dut (
      .clk(clk), .rst(rst), .addr(addr), .wen(wen), .ren(ren), .wdata(wdata), .rdata(rdata),
      .sw_in(sw_in), .btn_in(btn_in), .led_out(led_out), .seg_an(seg_an), .seg_cat(seg_cat),
      .irq(irq)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [7:0] o, input logic [31:0] d);
      addr  = BASE | {24'b0, o};
      wdata = d;
      wen   = 1'b1;
      @(negedge clk);
      wen   = 1'b0;
      wdata = '0;
   endtask

   task automatic rd(input string tag, input logic [7:0] o, input logic [31:0] exp);
      addr = BASE | {24'b0, o};
      ren  = 1'b1;
      #1;
      chk(tag, rdata, exp);
      ren  = 1'b0;
   endtask

   task automatic press();
      btn_in = 1'b1;
      tick(7);
      btn_in = 1'b0;
      tick(7);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; wen = 1'b0; ren = 1'b0; addr = '0; wdata = '0;
      btn_in = 1'b0; sw_in = 16'h1234;
      tick(3);
      rst = 1'b0;

      // Reset state and first digit timing
      tick(1);
      chk("an_e1", 32'(seg_an), 32'hF);
      chk("cat_e1", 32'(seg_cat), 32'hFF);
      rd("led_rst", 8'h10, 32'h0);
      rd("segval_rst", 8'h20, 32'h0);
      rd("stat_rst", 8'h04, 32'h0);
      rd("irqen_rst", 8'h08, 32'h0);
      tick(1);
      chk("an_e2", 32'(seg_an), 32'hF);
      tick(1);
      chk("an_e3", 32'(seg_an), 32'hE);
      chk("cat_e3", 32'(seg_cat), 32'hC0);
      rd("sw_sync", 8'h00, 32'h0000_1234);

      sw_in = 16'hBEEF;
      tick(1);
      rd("sw_lag1", 8'h00, 32'h0000_1234);
      tick(1);
      rd("sw_lag2", 8'h00, 32'h0000_BEEF);

      // LED register and address decode
      wr(8'h10, 32'h0001_A5A5);
      chk("led_out", 32'(led_out), 32'h0000_A5A5);
      rd("led_rd", 8'h10, 32'h0000_A5A5);
      wr(8'h14, 32'hFFFF_FFFF);
      rd("unmapped_rd", 8'h14, 32'h0);
      rd("led_after_unmapped", 8'h10, 32'h0000_A5A5);
      addr = 32'hFFFF_FD10; wdata = 32'h0000_1111; wen = 1'b1;
      tick(1);
      wen = 1'b0;
      chk("led_outside_win", 32'(led_out), 32'h0000_A5A5);
      addr = 32'hFFFF_FD10; ren = 1'b1; #1;
      chk("rd_outside_win", rdata, 32'h0);
      ren = 1'b0;
      addr = BASE | 32'h10; #1;
      chk("rd_ren_low", rdata, 32'h0);
      addr = BASE | 32'h13; ren = 1'b1; #1;
      chk("rd_low_bits_ignored", rdata, 32'h0000_A5A5);
      ren = 1'b0;

      // Button debounce latency
      btn_in = 1'b1;
      tick(5);
      rd("stat_edge5", 8'h04, 32'h0);
      tick(1);
      rd("stat_edge6", 8'h04, 32'h0000_0007);
      btn_in = 1'b0;
      tick(7);
      rd("stat_release", 8'h04, 32'h0000_0005);

      // Bounce never settles long enough
      for (int i = 0; i < 3; i++) begin
         btn_in = ~i[0];
         tick(2);
      end
      btn_in = 1'b0;
      tick(8);
      rd("stat_bounce", 8'h04, 32'h0000_0005);

      // Clearing and set-wins-over-clear
      do_reset();
      press();
      press();
      rd("stat_two", 8'h04, 32'h0000_0009);
      wr(8'h04, 32'hFFFF_FFFE);
      rd("stat_noclr", 8'h04, 32'h0000_0009);
      wr(8'h04, 32'h0000_0001);
      rd("stat_clr", 8'h04, 32'h0000_0008);
      btn_in = 1'b1;
      tick(5);
      wr(8'h04, 32'h0000_0001);
      rd("stat_set_wins", 8'h04, 32'h0000_000F);
      btn_in = 1'b0;
      tick(7);
      rd("stat_three", 8'h04, 32'h0000_000D);

      // Event counter wrap
      repeat (252) press();
      rd("stat_cnt255", 8'h04, 32'h0000_03FD);
      press();
      rd("stat_wrap", 8'h04, 32'h0000_0001);

      // Reset mid-debounce produces no event
      btn_in = 1'b1;
      tick(4);
      rst = 1'b1;
      btn_in = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(8);
      rd("stat_rst_abort", 8'h04, 32'h0);

      // Display scan sequence
      do_reset();
      wr(8'h20, 32'h0000_80F3);
      wr(8'h24, 32'h0000_0104);
      tick(1);
      chk("scan_d0_an", 32'(seg_an), 32'hE);
      chk("scan_d0_cat", 32'(seg_cat), 32'h30);
      tick(1);
      chk("scan_d0_hold", 32'(seg_an), 32'hE);
      tick(2);
      chk("scan_d1_an", 32'(seg_an), 32'hD);
      chk("scan_d1_cat", 32'(seg_cat), 32'h8E);
      tick(3);
      chk("scan_d2_blank", 32'(seg_an), 32'hF);
      tick(3);
      chk("scan_d3_an", 32'(seg_an), 32'h7);
      chk("scan_d3_cat", 32'(seg_cat), 32'h80);
      tick(3);
      chk("scan_wrap_an", 32'(seg_an), 32'hE);
      chk("scan_wrap_cat", 32'(seg_cat), 32'h30);
      rd("segval_rd", 8'h20, 32'h0000_80F3);
      rd("segctl_rd", 8'h24, 32'h0000_0104);
      wr(8'h20, 32'h0000_80A3);
      chk("segval_not_yet", 32'(seg_cat), 32'h30);
      tick(2);
      chk("segval_new_an", 32'(seg_an), 32'hD);
      chk("segval_new_cat", 32'(seg_cat), 32'h88);

      // Interrupt
`ifdef IO_HUB_IRQ_EN
      wr(8'h08, 32'h0000_0001);
      rd("irqen_rd", 8'h08, 32'h0000_0001);
      btn_in = 1'b1;
      tick(6);
      rd("irq_evt", 8'h04, 32'h0000_0007);
      chk("irq_lag", 32'(irq), 32'h0);
      tick(1);
      chk("irq_set", 32'(irq), 32'h1);
      wr(8'h04, 32'h0000_0001);
      chk("irq_clr_lag", 32'(irq), 32'h1);
      tick(1);
      chk("irq_clr", 32'(irq), 32'h0);
      btn_in = 1'b0;
      tick(7);
`else
      wr(8'h08, 32'h0000_0001);
      rd("irqen_rd", 8'h08, 32'h0);
      btn_in = 1'b1;
      tick(8);
      rd("irq_evt", 8'h04, 32'h0000_0007);
      chk("irq_tied", 32'(irq), 32'h0);
      btn_in = 1'b0;
      tick(7);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
